// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the "!" command frame, used by both the
// command receiver and the command transmitter.
package uart_cmd_pkg;

  localparam logic [7:0] SOF       = 8'h21;
  localparam logic [7:0] CH_M      = 8'h4D;
  localparam logic [7:0] CH_G      = 8'h47;
  localparam logic [7:0] CH_B      = 8'h42;
  localparam int         FRAME_LEN = 4;

  typedef enum logic [1:0] {
    SEL_M   = 2'd0,
    SEL_G   = 2'd1,
    SEL_B   = 2'd2,
    SEL_INV = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_NEXT = 2'd2
  } frame_state_e;

  function automatic logic [7:0] sel_char(input sel_e s);
    case (s)
      SEL_M:   return CH_M;
      SEL_G:   return CH_G;
      default: return CH_B;
    endcase
  endfunction

  // Payload bytes wrap mod 256; the receiver subtracts the same offset.
  function automatic logic [7:0] add_offset(input logic [7:0] b, input logic [7:0] off);
    return b + off;
  endfunction

endpackage

// File: rtl/uart_cmd_tx_if.sv
// Request/status bundle between a command source and the frame transmitter.
interface uart_cmd_tx_if;

  logic        send;
  logic [1:0]  sel;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic        oData;

  modport master (output send, sel, value, input busy, done, oData);
  modport slave  (input send, sel, value, output busy, done, oData);

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. done is high in the last cycle of the stop bit so a
// new start on that same edge chains bytes with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       done,
  output logic       active
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_active;
  logic             w_bit_end;
  logic             w_load;

  assign w_bit_end = r_active && (r_cnt == CNT_LAST);
  assign done      = w_bit_end && (r_bit == 4'd9);
  assign w_load    = start && (!r_active || done);
  assign tx        = r_tx;
  assign active    = r_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_tx     <= 1'b1;
    end else if (w_load) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_tx     <= 1'b0;
    end else if (w_bit_end) begin
      r_cnt <= '0;
      if (r_bit == 4'd9) begin
        r_active <= 1'b0;
        r_bit    <= '0;
        r_tx     <= 1'b1;
      end else begin
        r_bit <= r_bit + 4'd1;
        r_tx  <= (r_bit == 4'd8) ? 1'b1 : r_shift[0];
      end
    end else if (r_active) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Data bits leave LSB first; the shifter advances once per data bit.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_shift <= byte_in;
    end else if (w_bit_end && (r_bit < 4'd8)) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// Frames a 16-bit command into the 4-byte "!" frame and sends it over a UART
// line. The next byte is handed to the serializer on its done edge.
module uart_cmd_tx
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int OFFSET       = 30
) (
  input logic           clk,
  input logic           rst,
  uart_cmd_tx_if.slave  bus
);

  frame_state_e r_state;
  frame_state_e w_state_nxt;
  logic [1:0]   r_idx;
  logic [1:0]   w_idx_nxt;
  logic [7:0]   r_buf [FRAME_LEN];
  logic         w_accept;
  logic         w_ser_start;
  logic [7:0]   w_ser_byte;
  logic         w_ser_done;
  logic         w_ser_active;
  logic         w_tx;
  logic         w_done;
  sel_e         w_sel;

  assign w_sel = sel_e'(bus.sel);

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .start   (w_ser_start),
    .byte_in (w_ser_byte),
    .tx      (w_tx),
    .done    (w_ser_done),
    .active  (w_ser_active)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // The final NEXT cycle is also an accept window, so back-to-back frames
  // are separated only by the single done cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_accept    = 1'b0;
    w_ser_start = 1'b0;
    w_ser_byte  = SOF;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = bus.send && (w_sel != SEL_INV);
      end
      ST_SEND: begin
        if (w_ser_done) begin
          w_state_nxt = ST_NEXT;
          if (r_idx != 2'd3) begin
            w_ser_start = 1'b1;
            w_ser_byte  = r_buf[r_idx + 2'd1];
          end
        end
      end
      ST_NEXT: begin
        if (r_idx != 2'd3) begin
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = ST_SEND;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
          w_accept    = bus.send && (w_sel != SEL_INV);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_accept) begin
      w_ser_start = 1'b1;
      w_ser_byte  = SOF;
      w_idx_nxt   = '0;
      w_state_nxt = ST_SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[0] <= SOF;
      r_buf[1] <= sel_char(w_sel);
      r_buf[2] <= add_offset(bus.value[15:8], 8'(OFFSET));
      r_buf[3] <= add_offset(bus.value[7:0], 8'(OFFSET));
    end
  end

  assign bus.busy  = w_ser_active;
  assign bus.done  = w_done;
  assign bus.oData = w_tx;

endmodule
